// File: rtl/sha256_pkg.sv
// Shared widths, small-sigma rotate/shift amounts and the schedule FSM state
// for the SHA-256 message-schedule expander.
package sha256_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLOCK_WORDS = 16;
  localparam int unsigned ROUNDS      = 64;
  localparam int unsigned SLOT_W      = 4;
  localparam int unsigned IDX_W       = 6;

  localparam int unsigned S0_R1 = 7;
  localparam int unsigned S0_R2 = 18;
  localparam int unsigned S0_SH = 3;
  localparam int unsigned S1_R1 = 17;
  localparam int unsigned S1_R2 = 19;
  localparam int unsigned S1_SH = 10;

  typedef enum logic {
    LOAD = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/sha256_small_sigma.sv
// SHA-256 small sigma: ROTR(R1) ^ ROTR(R2) ^ SHR(SH), purely combinational.
module sha256_small_sigma
  import sha256_pkg::*;
#(
  parameter int unsigned R1 = S0_R1,
  parameter int unsigned R2 = S0_R2,
  parameter int unsigned SH = S0_SH
) (
  input  logic [WORD_W-1:0] x_i,
  output logic [WORD_W-1:0] y_o
);

  assign y_o = {x_i[R1-1:0], x_i[WORD_W-1:R1]}
             ^ {x_i[R2-1:0], x_i[WORD_W-1:R2]}
             ^ (x_i >> SH);

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, then streams W[0..63], expanding
// W[t>=16] in place inside a 16-word circular window.
module sha256_msg_schedule
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last
);

  state_e             state_q;
  logic [SLOT_W-1:0]  load_cnt_q;
  logic [IDX_W-1:0]   t_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [WORD_W-1:0]  win_q [BLOCK_WORDS];

  logic [SLOT_W-1:0]  slot_t, slot_m2, slot_m7, slot_m15;
  logic [WORD_W-1:0]  sig0, sig1, expand_c, word_c;
  logic               early_c, in_fire, out_fire, last_c;

  // Modulo-16 window slots come from the low bits of t wrapping naturally.
  assign slot_t   = t_q[SLOT_W-1:0];
  assign slot_m2  = slot_t - 4'd2;
  assign slot_m7  = slot_t - 4'd7;
  assign slot_m15 = slot_t - 4'd15;

  sha256_small_sigma #(.R1(S0_R1), .R2(S0_R2), .SH(S0_SH)) u_s0 (
    .x_i (win_q[slot_m15]),
    .y_o (sig0)
  );

  sha256_small_sigma #(.R1(S1_R1), .R2(S1_R2), .SH(S1_SH)) u_s1 (
    .x_i (win_q[slot_m2]),
    .y_o (sig1)
  );

  assign expand_c = sig1 + win_q[slot_m7] + sig0 + win_q[slot_t];
  assign early_c  = (t_q[IDX_W-1:SLOT_W] == 2'b00);
  assign word_c   = early_c ? win_q[slot_t] : expand_c;
  assign last_c   = (t_q == IDX_W'(ROUNDS - 1));
  assign in_fire  = in_ready_q & in_valid;
  assign out_fire = out_valid_q & out_ready;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_valid_q ? word_c : '0;
  assign out_index = t_q;
  assign out_last  = out_valid_q & last_c;

  // Control FSM; in_ready/out_valid are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      load_cnt_q  <= '0;
      t_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (in_fire) begin
            load_cnt_q <= load_cnt_q + 4'd1;
            if (load_cnt_q == SLOT_W'(BLOCK_WORDS - 1)) begin
              state_q     <= EMIT;
              t_q         <= '0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (last_c) begin
              state_q     <= LOAD;
              load_cnt_q  <= '0;
              t_q         <= '0;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
            end else begin
              t_q <= t_q + 6'd1;
            end
          end
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  // Window storage: loaded words in LOAD, expanded words overwrite W[t-16].
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == LOAD && in_fire) begin
        win_q[load_cnt_q] <= in_data;
      end else if (state_q == EMIT && out_fire && !early_c) begin
        win_q[slot_t] <= expand_c;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed + randomized bench for sha256_msg_schedule against a full 64-word
// schedule model built from the SHA-256 recurrence.
module tb_sha256_msg_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_index;
  logic        out_last;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] msg  [16];
  logic [31:0] wref [64];
  logic [31:0] cap  [64];

  sha256_msg_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic void build_ref();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) wref[t] = msg[t];
      else wref[t] = ssig1(wref[t-2]) + wref[t-7] + ssig0(wref[t-15]) + wref[t-16];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'h0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    build_ref();
  endtask

  task automatic set_rand();
    for (int i = 0; i < 16; i++) msg[i] = $urandom;
    build_ref();
  endtask

  task automatic set_const(input logic [31:0] v);
    for (int i = 0; i < 16; i++) msg[i] = v;
    build_ref();
  endtask

  // Push msg[0..15]; with gaps, in_valid drops for a cycle between words.
  task automatic load_block(input bit gaps);
    for (int i = 0; i < 16; i++) begin
      int w;
      in_valid = 1'b1;
      in_data  = msg[i];
      w = 0;
      while (in_ready !== 1'b1 && w < 50) begin
        tick();
        w++;
      end
      chk($sformatf("in_ready_load%0d", i), 32'(in_ready), 32'd1);
      chk($sformatf("out_valid_load%0d", i), 32'(out_valid), 32'd0);
      tick();
      if (gaps && i < 15) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        tick();
      end
    end
    in_valid = gaps;
    in_data  = $urandom;
  endtask

  // Consume W[0..stop_at-1], optionally stalling before the handshake at stall_at.
  task automatic drain(input int stop_at, input int stall_at, input int stall_n);
    out_ready = 1'b1;
    for (int t = 0; t < stop_at; t++) begin
      chk($sformatf("out_valid_t%0d", t), 32'(out_valid), 32'd1);
      chk($sformatf("out_index_t%0d", t), 32'(out_index), 32'(t));
      chk($sformatf("W%0d", t), out_data, wref[t]);
      chk($sformatf("out_last_t%0d", t), 32'(out_last), 32'(t == 63));
      chk($sformatf("in_ready_emit_t%0d", t), 32'(in_ready), 32'd0);
      cap[t] = out_data;
      if (t == stall_at) begin
        out_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          tick();
          chk($sformatf("hold_W%0d", t), out_data, wref[t]);
          chk($sformatf("hold_index%0d", t), 32'(out_index), 32'(t));
          chk($sformatf("hold_valid%0d", t), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    if (stop_at == 64) begin
      chk("in_ready_after_last", 32'(in_ready), 32'd1);
      chk("out_valid_after_last", 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", out_data, 32'd0);

    // "abc" padded block at full throughput
    set_abc();
    load_block(1'b0);
    drain(64, -1, 0);
    chk("abc_W0", cap[0], 32'h61626380);
    chk("abc_W15", cap[15], 32'h00000018);
    chk("abc_W16", cap[16], 32'h61626380);
    chk("abc_W17", cap[17], 32'h000F0000);
    chk("abc_W18", cap[18], 32'h7DA86405);
    chk("abc_W19", cap[19], 32'h600003C6);

    // All-ones block exercises modular wrap of the four-term sum
    set_const(32'hFFFFFFFF);
    load_block(1'b0);
    drain(64, -1, 0);
    chk("ones_W16", cap[16], 32'h203FFFFC);

    // Backpressure at t=17 on the "abc" block
    set_abc();
    load_block(1'b0);
    drain(64, 17, 5);
    chk("bp_W17", cap[17], 32'h000F0000);
    chk("bp_W18", cap[18], 32'h7DA86405);
    chk("bp_W19", cap[19], 32'h600003C6);

    // Gapped input, in_valid left high throughout EMIT
    set_rand();
    load_block(1'b1);
    drain(64, -1, 0);
    in_valid = 1'b0;

    // Reset in the middle of EMIT, then an all-zero block
    set_rand();
    load_block(1'b0);
    drain(30, -1, 0);
    chk("pre_rst_index", 32'(out_index), 32'd30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_index", 32'(out_index), 32'd0);
    set_const(32'h0);
    load_block(1'b0);
    drain(64, -1, 0);

    // Back-to-back random blocks with a random stall in the second
    set_rand();
    load_block(1'b0);
    drain(64, -1, 0);
    set_rand();
    load_block(1'b0);
    drain(64, int'($urandom_range(0, 63)), int'($urandom_range(1, 4)));
    chk("b2b_W0", cap[0], msg[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
